spi_reg_master: RTL and testbench
=================================

Name: spi_reg_master

Overview:
SPI controller that drives register read/write frames into the SPI register-bank peripheral on the same bus. It issues one frame per accepted request. It serves an on-chip host (test sequencer, config loader) through a valid/ready request port and a one-cycle response pulse. The bus is SPI mode 0, MSB first, with one peripheral per instance.

Parameters:
ADDR_W, 3, register address width; must be ≤7.
REG_W, 8, register data width.
CLK_DIV, 4, spi_clk half-period in clk cycles; must be ≥2.
CS_GAP, 2, minimum clk cycles with spi_cs_n high between frames.

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
ena  input  1  block enable; gates request acceptance only
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  target register address
req_wdata  input  REG_W  write data; ignored for reads
rsp_valid  output  1  one-cycle pulse at frame completion
rsp_rdata  output  REG_W  data captured from spi_miso during the data phase
busy  output  1  high from acceptance until GAP ends
spi_cs_n  output  1  chip select, active low
spi_clk  output  1  serial clock, idles low
spi_mosi  output  1  serial data out
spi_miso  input  1  serial data in

Behaviour:
- Clock and reset: one clock `clk`; reset `rstb` is asynchronous and active-low.
- Reset values: spi_cs_n=1, spi_clk=0, spi_mosi=0, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, busy=0, FSM=IDLE.
- Frame format: FRAME_W = 8+REG_W bits, MSB first.
  - Command byte: bit7 = req_write; bits6..ADDR_W = 0; bits ADDR_W-1..0 = req_addr.
  - Data field: REG_W bits. Writes send req_wdata; reads send zeros.
- Handshake:
  - req_ready = ena && state==IDLE.
  - Transfer occurs on a clk edge where req_valid && req_ready.
  - Command and data are latched into a FRAME_W shift register at that edge.
  - Request inputs are don't-care afterwards.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  - IDLE: cs_n=1, sclk=0. On transfer, go to SETUP. From the next cycle cs_n=0 and mosi=frame MSB.
  - SETUP: lasts CLK_DIV cycles with sclk low, then go to SHIFT.
  - SHIFT: per bit, sclk is high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - On the clk edge that raises sclk, sample spi_miso into the receive shift register.
    - On the edge that lowers sclk, shift mosi to the next bit. On the last bit, mosi holds.
    - A bit counter counts 0..FRAME_W-1. After the falling edge of bit FRAME_W-1, go to HOLD.
  - HOLD: sclk=0, cs_n=0 for CLK_DIV cycles. Then cs_n=1, rsp_valid pulses for exactly one cycle, rsp_rdata = the last REG_W sampled bits, go to GAP.
  - GAP: CS_GAP cycles with cs_n=1, then IDLE.
- rsp_rdata holds its value until the next rsp_valid.
  - It is updated for writes as well; the host ignores it for writes.
- Frame length in clk cycles, from acceptance to rsp_valid: 1 + CLK_DIV + 2*CLK_DIV*FRAME_W + CLK_DIV.
  - Default: 1+4+128+4 = 137.
- Back-to-back requests: earliest next acceptance is CS_GAP+1 cycles after the rsp_valid cycle.
- ena deasserted mid-frame: the current frame completes normally; no new acceptance until ena=1.
- req_valid held while busy: no effect and no queuing.
- Reset mid-frame: outputs return immediately (asynchronously) to reset values. No rsp_valid is generated. The peripheral sees cs_n rise and discards the partial frame.
- spi_miso is sampled directly; the peripheral launches MISO on the falling sclk edge, giving a CLK_DIV-cycle setup margin.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - CMD_W=8 and CMD_RW_BIT=7
  - function building the command byte from rw and addr
- Sub-module spi_sclk_gen:
  - CLK_DIV counter producing spi_clk
  - one-cycle rise_evt and fall_evt strobes
  - enabled only in SHIFT
- The top holds the FSM, the bit counter and both shift registers.

Test Plan:
- Write addr=5, data=0xA5 with a peripheral model: MOSI bits = 0x85,0xA5. spi_cs_n is low for exactly 136 cycles. rsp_valid pulses once, at cycle 137 after acceptance. The model register 5 reads 0xA5.
- Read addr=3, peripheral returns 0x3C: MOSI = 0x03,0x00 and rsp_rdata=0x3C on the rsp_valid cycle. Repeat with 0xFF and 0x00 for stuck-bit coverage.
- Two requests with req_valid held high: the second accepted exactly CS_GAP+1=3 cycles after the first rsp_valid, with spi_cs_n high ≥2 cycles between frames.
- ena=0 with req_valid=1: req_ready=0 and no SPI activity. Drop ena mid-frame: the frame completes and rsp_valid is still asserted.
- rstb pulsed low at bit 7 of a frame: spi_cs_n=1, spi_clk=0 immediately and no rsp_valid. A new write after reset completes correctly.
- CLK_DIV=2, REG_W=16 build: frame = 24 bits and latency = 1+2+96+2 = 101 cycles; a read returns 0xBEEF.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-bank master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int CMD_W      = 8;
  localparam int CMD_RW_BIT = 7;

  // Command byte: R/W flag on top, address zero-extended below it.
  function automatic logic [CMD_W-1:0] build_cmd(input logic rw,
                                                 input logic [CMD_RW_BIT-1:0] addr);
    return {rw, addr};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock divider: spi_clk toggles every CLK_DIV clk cycles while enabled,
// with strobes marking the clk edge on which spi_clk rises or falls.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  output logic spi_clk,
  output logic phase_end,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Parked at the terminal count so the first enabled edge raises spi_clk.
  assign phase_end = (div_q == DIV_LAST);
  assign rise_evt  = en && phase_end && !spi_clk;
  assign fall_evt  = en && phase_end && spi_clk;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_q   <= DIV_LAST;
      spi_clk <= 1'b0;
    end else if (!en) begin
      div_q   <= DIV_LAST;
      spi_clk <= 1'b0;
    end else if (phase_end) begin
      div_q   <= '0;
      spi_clk <= !spi_clk;
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing one register read/write frame per accepted request.
// Holds the frame FSM, the bit counter and the transmit/receive shift registers.
module spi_reg_master
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int REG_W   = 8,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [REG_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int FRAME_W = CMD_W + REG_W;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP + 1) ? CLK_DIV : CS_GAP + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(FRAME_W);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_q;
  logic [FRAME_W-1:0] tx_q;
  logic [REG_W-1:0]   rx_q;
  logic [FRAME_W-1:0] frame;
  logic               accept, last_bit, div_done, sclk_en, rise_evt, fall_evt, frame_end;

  assign req_ready = rstb && ena && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != ST_IDLE);
  assign last_bit  = (bit_q == BIT_W'(FRAME_W - 1));
  assign spi_mosi  = tx_q[FRAME_W-1];
  assign frame     = {build_cmd(req_write, (CMD_W - 1)'(req_addr)),
                      req_write ? req_wdata : {REG_W{1'b0}}};
  assign frame_end = (state_q == ST_HOLD) && (state_d == ST_GAP);

  // The divider also times SETUP's final cycle so the first rise lands as SHIFT begins.
  assign sclk_en = (state_d == ST_SHIFT);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .rstb      (rstb),
    .en        (sclk_en),
    .spi_clk   (spi_clk),
    .phase_end (div_done),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (cnt_q == CNT_W'(CLK_DIV - 1)) state_d = ST_SHIFT;
      ST_SHIFT: if (div_done && !spi_clk && last_bit) state_d = ST_HOLD;
      ST_HOLD:  if (cnt_q == CNT_W'(CLK_DIV - 1)) state_d = ST_GAP;
      // GAP covers the response cycle plus CS_GAP idle cycles with chip select high.
      ST_GAP:   if (cnt_q == CNT_W'(CS_GAP)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      spi_cs_n  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      spi_cs_n  <= !(state_d inside {ST_SETUP, ST_SHIFT, ST_HOLD});
      rsp_valid <= frame_end;

      if (accept) begin
        tx_q  <= frame;
        bit_q <= '0;
      end else if (fall_evt && !last_bit) begin
        tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
      end

      // The first rise happens on SETUP's last edge and belongs to bit 0.
      if (rise_evt) begin
        rx_q <= {rx_q[REG_W-2:0], spi_miso};
        if (state_q == ST_SHIFT) bit_q <= bit_q + 1'b1;
      end

      if (frame_end) rsp_rdata <= rx_q;
    end
  end

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench: register-bank peripheral model, vector table, and corner-case sequences.
module tb_spi_reg_master;

  logic clk = 1'b0;
  logic rstb, ena, req_valid, req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic req_ready, rsp_valid, busy, spi_cs_n, spi_clk, spi_mosi, spi_miso;
  logic [7:0] rsp_rdata;

  logic b_valid, b_write, b_ready, b_rsp_valid, b_busy, b_cs_n, b_sclk, b_mosi, b_miso;
  logic [2:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;

  always #5 clk = ~clk;

  spi_reg_master dut (
    .clk(clk), .rstb(rstb), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_reg_master #(.ADDR_W(3), .REG_W(16), .CLK_DIV(2), .CS_GAP(2)) dut16 (
    .clk(clk), .rstb(rstb), .ena(1'b1), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy), .spi_cs_n(b_cs_n),
    .spi_clk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  // Peripheral model for the 8-bit build: register bank, MISO launched on falling sclk.
  logic [7:0]  p_regs [8];
  logic [15:0] p_rx, p_last;
  logic [7:0]  p_tx;
  logic        p_miso = 1'b0;
  int          p_cnt = 0, p_last_cnt = 0;
  assign spi_miso = p_miso;

  always @(negedge spi_cs_n) begin p_cnt = 0; p_miso = 1'b0; end
  always @(posedge spi_clk) if (!spi_cs_n) begin p_rx = {p_rx[14:0], spi_mosi}; p_cnt++; end
  always @(negedge spi_clk) if (!spi_cs_n) begin
    if (p_cnt == 8) p_tx = p_regs[p_rx[2:0]];
    if (p_cnt >= 8 && p_cnt < 16) p_miso = p_tx[15-p_cnt];
  end
  always @(posedge spi_cs_n) begin
    p_last = p_rx; p_last_cnt = p_cnt;
    if (p_cnt == 16 && p_rx[15]) p_regs[p_rx[10:8]] = p_rx[7:0];
  end

  // Peripheral model for the 16-bit build: fixed 24-bit response pattern.
  logic [23:0] b_out, b_rx, b_last;
  initial b_miso = 1'b0;
  always @(negedge b_cs_n) begin b_out = 24'h00BEEF; b_miso = b_out[23]; end
  always @(posedge b_sclk) if (!b_cs_n) b_rx = {b_rx[22:0], b_mosi};
  always @(negedge b_sclk) if (!b_cs_n) begin b_out = b_out << 1; b_miso = b_out[23]; end
  always @(posedge b_cs_n) b_last = b_rx;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request on the 8-bit build. Cycle 0 is the acceptance cycle.
  task automatic run_txn(input bit w, input logic [2:0] a, input logic [7:0] d,
                         output int lat, output int cs_low, output logic [7:0] rd,
                         output bit cs_hi_at_rsp, output bit pulse_once, output bit to);
    int n;
    to = 1'b0; lat = 0; cs_low = 0; rd = '0; cs_hi_at_rsp = 1'b0; pulse_once = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      if (!spi_cs_n) cs_low++;
      @(negedge clk); lat++;
    end
    if (!rsp_valid) begin to = 1'b1; return; end
    rd = rsp_rdata;
    cs_hi_at_rsp = spi_cs_n;
    @(negedge clk);
    pulse_once = !rsp_valid;
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    bit         pre;
    logic [7:0] preload;
    logic [15:0] exp_mosi;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cs_low, n, gap, hi, viol;
    logic [7:0] rd;
    bit cs_hi, once, to;

    vecs[0] = '{1'b1, 3'd5, 8'hA5, 1'b1, 8'h00, 16'h85A5, 8'h00};
    vecs[1] = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h3C, 16'h0300, 8'h3C};
    vecs[2] = '{1'b0, 3'd3, 8'h00, 1'b1, 8'hFF, 16'h0300, 8'hFF};
    vecs[3] = '{1'b0, 3'd3, 8'h5A, 1'b1, 8'h00, 16'h0300, 8'h00};
    vecs[4] = '{1'b1, 3'd7, 8'h5A, 1'b1, 8'hC3, 16'h875A, 8'hC3};
    vecs[5] = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 16'h0500, 8'hA5};

    for (int i = 0; i < 8; i++) p_regs[i] = 8'h00;
    rstb = 1'b0; ena = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    rstb = 1'b1;
    @(negedge clk);
    check("idle_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre) p_regs[vecs[i].addr] = vecs[i].preload;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, cs_low, rd, cs_hi, once, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_latency", i), lat, 137);
      check($sformatf("v%0d_cs_low", i), cs_low, 136);
      check($sformatf("v%0d_cs_hi_rsp", i), cs_hi, 1);
      check($sformatf("v%0d_pulse_once", i), once, 1);
      check($sformatf("v%0d_mosi", i), p_last, vecs[i].exp_mosi);
      check($sformatf("v%0d_bits", i), p_last_cnt, 16);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].wr) check($sformatf("v%0d_reg", i), p_regs[vecs[i].addr], vecs[i].wdata);
    end

    // Back-to-back with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd2; req_wdata = 8'h3C;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    lat = 0;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    check("b2b_first_latency", lat, 137);
    gap = 0; hi = spi_cs_n ? 1 : 0;
    while (!req_ready && gap < 50) begin
      @(negedge clk); gap++;
      if (spi_cs_n) hi++;
    end
    check("b2b_accept_gap", gap, 3);
    check("b2b_cs_high_min", (hi >= 2), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_cs_low", spi_cs_n, 0);
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    check("b2b_second_latency", lat, 137);
    check("b2b_second_mosi", p_last, 16'h823C);
    repeat (4) @(negedge clk);

    // ena low: requests refused, bus stays idle.
    ena = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h0F;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready || !spi_cs_n || spi_clk || busy) viol++;
    end
    check("ena_off_idle", viol, 0);

    // ena dropped mid-frame with req_valid still held.
    ena = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      if (lat == 10) ena = 1'b0;
      @(negedge clk); lat++;
    end
    check("ena_drop_latency", lat, 137);
    check("ena_drop_mosi", p_last, 16'h810F);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready || !spi_cs_n || rsp_valid) viol++;
    end
    check("ena_drop_no_new", viol, 0);
    req_valid = 1'b0;
    ena = 1'b1;
    @(negedge clk);

    // Reset pulse during bit 7 of a write.
    p_regs[6] = 8'h77;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_wdata = 8'h11;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (62) @(negedge clk);
    check("rst_mid_bits", p_cnt, 8);
    check("rst_mid_busy", busy, 1);
    #2 rstb = 1'b0;
    #1;
    check("rst_mid_cs_n", spi_cs_n, 1);
    check("rst_mid_sclk", spi_clk, 0);
    check("rst_mid_busy_low", busy, 0);
    check("rst_mid_ready", req_ready, 0);
    @(negedge clk);
    rstb = 1'b1;
    viol = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid) viol++;
    end
    check("rst_mid_no_rsp", viol, 0);
    check("rst_mid_reg_kept", p_regs[6], 8'h77);
    run_txn(1'b1, 3'd6, 8'h42, lat, cs_low, rd, cs_hi, once, to);
    check("rst_after_latency", lat, 137);
    check("rst_after_reg", p_regs[6], 8'h42);

    // 16-bit register, CLK_DIV=2 build: read returns 0xBEEF.
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b0; b_addr = 3'd2; b_wdata = 16'h1234;
    n = 0;
    while (!b_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    b_valid = 1'b0;
    lat = 1; cs_low = 0;
    while (!b_rsp_valid && lat < 400) begin
      if (!b_cs_n) cs_low++;
      @(negedge clk); lat++;
    end
    check("w16_latency", lat, 101);
    check("w16_cs_low", cs_low, 100);
    check("w16_rdata", b_rdata, 16'hBEEF);
    check("w16_mosi", b_last, 24'h020000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
